// File: rtl/enemy_spawn_pkg.sv
// rtl/enemy_spawn_pkg.sv - shared types, defaults and width helper for the spawn pattern generator
package enemy_spawn_pkg;

  typedef enum logic {
    SPAWN_ROTATE = 1'b0,
    SPAWN_LFSR   = 1'b1
  } spawn_mode_e;

  localparam int              DEF_WIDTH   = 16;
  localparam int              DEF_NUM_CH  = 4;
  localparam logic [15:0]     DEF_TAPS    = 16'hB400;
  localparam int              DEF_MIN_GAP = 2;
  localparam logic [63:0]     DEF_SEEDS   = 64'h1911_1191_1119_9111;

  // Bits needed to index n items; never less than one so ports stay legal.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/enemy_spawn_channel.sv
// rtl/enemy_spawn_channel.sv - one spawn lane: pattern register, holdoff, step counter, output flops
module enemy_spawn_channel
  import enemy_spawn_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS    = WIDTH'(DEF_TAPS),
  parameter int               MIN_GAP = DEF_MIN_GAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             load,
  input  spawn_mode_e      mode,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] load_data,
  output logic             spawn,
  output logic             wrap
);

  localparam int CW = cnt_width(WIDTH);
  localparam int HW = cnt_width(MIN_GAP + 1);

  logic [WIDTH-1:0] pattern;
  logic [WIDTH-1:0] pattern_next;
  logic [CW-1:0]    step_cnt;
  logic [HW-1:0]    holdoff;
  logic             out_bit;
  logic             last_step;

  assign last_step = (step_cnt == CW'(WIDTH - 1));

  // Next pattern and emitted bit for an advance; an all-zero LFSR is recovered from the seed.
  always_comb begin
    out_bit      = pattern[0];
    pattern_next = pattern;
    if (mode == SPAWN_LFSR) begin
      if (pattern == '0) begin
        pattern_next = seed;
        out_bit      = 1'b0;
      end else begin
        pattern_next = (pattern >> 1) ^ (pattern[0] ? TAPS : '0);
      end
    end else begin
      pattern_next = {pattern[0], pattern[WIDTH-1:1]};
    end
  end

  // Channel state and registered one-cycle spawn/wrap pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern  <= seed;
      step_cnt <= '0;
      holdoff  <= '0;
      spawn    <= 1'b0;
      wrap     <= 1'b0;
    end else if (load) begin
      pattern  <= load_data;
      step_cnt <= '0;
      holdoff  <= '0;
      spawn    <= 1'b0;
      wrap     <= 1'b0;
    end else if (adv) begin
      pattern  <= pattern_next;
      wrap     <= last_step;
      step_cnt <= last_step ? '0 : step_cnt + CW'(1);
      if (holdoff != '0) begin
        holdoff <= holdoff - HW'(1);
        spawn   <= 1'b0;
      end else begin
        spawn <= out_bit;
        if (out_bit) begin
          holdoff <= HW'(MIN_GAP);
        end
      end
    end else begin
      spawn <= 1'b0;
      wrap  <= 1'b0;
    end
  end

endmodule

// File: rtl/enemy_spawn_pattern_gen.sv
// rtl/enemy_spawn_pattern_gen.sv - multi-lane spawn generator: load decode, enable gating, lane array
module enemy_spawn_pattern_gen
  import enemy_spawn_pkg::*;
#(
  parameter int                      WIDTH   = DEF_WIDTH,
  parameter int                      NUM_CH  = DEF_NUM_CH,
  parameter logic [NUM_CH*WIDTH-1:0] SEEDS   = DEF_SEEDS,
  parameter logic [WIDTH-1:0]        TAPS    = WIDTH'(DEF_TAPS),
  parameter int                      MIN_GAP = DEF_MIN_GAP
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          step,
  input  logic [NUM_CH-1:0]             ch_en,
  input  logic                          mode,
  input  logic                          load_en,
  input  logic [cnt_width(NUM_CH)-1:0]  load_ch,
  input  logic [WIDTH-1:0]              load_data,
  output logic [NUM_CH-1:0]             spawn,
  output logic [NUM_CH-1:0]             wrap
);

  localparam int LCW = cnt_width(NUM_CH);

  spawn_mode_e mode_sel;
  assign mode_sel = spawn_mode_e'(mode);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic load_hit;
    logic adv;

    // An out-of-range load_ch matches no lane, so such a load is dropped.
    assign load_hit = load_en && (load_ch == LCW'(c));
    assign adv      = step && ch_en[c] && !load_hit;

    enemy_spawn_channel #(
      .WIDTH   (WIDTH),
      .TAPS    (TAPS),
      .MIN_GAP (MIN_GAP)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .adv       (adv),
      .load      (load_hit),
      .mode      (mode_sel),
      .seed      (SEEDS[c*WIDTH +: WIDTH]),
      .load_data (load_data),
      .spawn     (spawn[c]),
      .wrap      (wrap[c])
    );
  end

endmodule

// File: tb/tb_enemy_spawn_pattern_gen.sv
// tb/tb_enemy_spawn_pattern_gen.sv - self-checking bench: three holdoff variants against a behavioural model
module tb_enemy_spawn_pattern_gen;

  localparam logic [63:0] SEEDS = 64'h1911_1191_1119_9111;
  localparam logic [15:0] TAPS  = 16'hB400;

  logic        clk = 1'b0;
  logic        rst;
  logic        step;
  logic [3:0]  ch_en;
  logic        mode;
  logic        load_en;
  logic [1:0]  load_ch;
  logic [15:0] load_data;
  logic [2:0][3:0] sp;
  logic [2:0][3:0] wr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  enemy_spawn_pattern_gen #(.MIN_GAP(0)) dut0 (
    .clk(clk), .rst(rst), .step(step), .ch_en(ch_en), .mode(mode), .load_en(load_en),
    .load_ch(load_ch), .load_data(load_data), .spawn(sp[0]), .wrap(wr[0]));
  enemy_spawn_pattern_gen #(.MIN_GAP(1)) dut1 (
    .clk(clk), .rst(rst), .step(step), .ch_en(ch_en), .mode(mode), .load_en(load_en),
    .load_ch(load_ch), .load_data(load_data), .spawn(sp[1]), .wrap(wr[1]));
  enemy_spawn_pattern_gen #(.MIN_GAP(2)) dut2 (
    .clk(clk), .rst(rst), .step(step), .ch_en(ch_en), .mode(mode), .load_en(load_en),
    .load_ch(load_ch), .load_data(load_data), .spawn(sp[2]), .wrap(wr[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per variant and lane, current pattern, total steps taken and remaining holdoff.
  int          gaps [3] = '{0, 1, 2};
  logic [15:0] m_pat   [3][4];
  int          m_steps [3][4];
  int          m_hold  [3][4];
  logic [3:0]  exp_sp  [3];
  logic [3:0]  exp_wr  [3];

  task model_update();
    for (int g = 0; g < 3; g++) begin
      for (int c = 0; c < 4; c++) begin
        logic b;
        exp_sp[g][c] = 1'b0;
        exp_wr[g][c] = 1'b0;
        if (rst) begin
          m_pat[g][c] = SEEDS[c*16 +: 16];
          m_steps[g][c] = 0;
          m_hold[g][c] = 0;
        end else if (load_en && int'(load_ch) == c) begin
          m_pat[g][c] = load_data;
          m_steps[g][c] = 0;
          m_hold[g][c] = 0;
        end else if (step && ch_en[c]) begin
          b = m_pat[g][c][0];
          if (mode) begin
            if (m_pat[g][c] == 16'h0) begin
              m_pat[g][c] = SEEDS[c*16 +: 16];
              b = 1'b0;
            end else begin
              m_pat[g][c] = (m_pat[g][c] >> 1) ^ (b ? TAPS : 16'h0);
            end
          end else begin
            m_pat[g][c] = (m_pat[g][c] >> 1) | (b ? 16'h8000 : 16'h0);
          end
          exp_wr[g][c] = (m_steps[g][c] % 16) == 15;
          m_steps[g][c]++;
          if (m_hold[g][c] > 0) begin
            m_hold[g][c]--;
          end else begin
            exp_sp[g][c] = b;
            if (b) m_hold[g][c] = gaps[g];
          end
        end
      end
    end
  endtask

  // Compare every DUT output against the model one time unit after each rising edge.
  always @(posedge clk) begin
    model_update();
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("model_spawn_g%0d", g), 32'(sp[g]), 32'(exp_sp[g]));
      chk($sformatf("model_wrap_g%0d", g),  32'(wr[g]), 32'(exp_wr[g]));
    end
  end

  task automatic cyc(input logic s, input logic [3:0] en, input logic m,
                     input logic le, input logic [1:0] lc, input logic [15:0] ld);
    step = s; ch_en = en; mode = m; load_en = le; load_ch = lc; load_data = ld;
    @(negedge clk);
  endtask

  int seq1 [16] = '{1,0,0,0, 1,0,0,0, 1,0,0,0, 1,0,0,1};
  int seq2 [4]  = '{1,0,0,0};
  int seq3 [3]  = '{1,0,0};

  initial begin
    rst = 1'b1;
    cyc(0, 4'b0000, 0, 0, 2'd0, 16'h0);
    cyc(0, 4'b0000, 0, 0, 2'd0, 16'h0);
    chk("reset_spawn", 32'(sp[2]), 0);
    chk("reset_wrap",  32'(wr[2]), 0);
    rst = 1'b0;

    // Rotate ch0 over two full periods, no holdoff.
    for (int k = 0; k < 32; k++) begin
      cyc(1, 4'b0001, 0, 0, 2'd0, 16'h0);
      chk($sformatf("t1_spawn_k%0d", k), 32'(sp[0][0]), 32'(seq1[k % 16]));
      chk($sformatf("t1_wrap_k%0d", k),  32'(wr[0][0]), 32'((k % 16) == 15));
    end

    // Holdoff of one suppresses the adjacent second bit.
    cyc(0, 4'b0000, 0, 1, 2'd1, 16'h0003);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 4'b0010, 0, 0, 2'd0, 16'h0);
      chk($sformatf("t2_spawn_k%0d", k), 32'(sp[1][1]), 32'(seq2[k]));
    end

    // LFSR from 0x0001, then lockup recovery from the ch2 seed 0x1191.
    cyc(0, 4'b0000, 1, 1, 2'd2, 16'h0001);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 4'b0100, 1, 0, 2'd0, 16'h0);
      chk($sformatf("t3_spawn_k%0d", k), 32'(sp[0][2]), 32'(seq3[k]));
    end
    cyc(0, 4'b0000, 1, 1, 2'd2, 16'h0000);
    cyc(1, 4'b0100, 1, 0, 2'd0, 16'h0);
    chk("t3_lockup_spawn", 32'({sp[2][2], sp[1][2], sp[0][2]}), 0);
    cyc(1, 4'b0100, 1, 0, 2'd0, 16'h0);
    chk("t3_reseed_spawn", 32'({sp[2][2], sp[1][2], sp[0][2]}), 32'h7);

    // Load ch0 while all lanes step; ch0 stays quiet, then counts from zero.
    cyc(1, 4'b1111, 0, 1, 2'd0, 16'h8001);
    chk("t4_load_spawn", 32'(sp[0][0]), 0);
    chk("t4_load_wrap",  32'(wr[0][0]), 0);
    for (int k = 0; k < 16; k++) begin
      cyc(1, 4'b0001, 0, 0, 2'd0, 16'h0);
      if (k == 0)  chk("t4_first_spawn", 32'(sp[0][0]), 1);
      if (k == 15) chk("t4_wrap16", 32'(wr[0][0]), 1);
    end

    // Reset mid-sequence with step held high.
    for (int k = 0; k < 7; k++) cyc(1, 4'b1111, 0, 0, 2'd0, 16'h0);
    rst = 1'b1;
    cyc(1, 4'b1111, 0, 0, 2'd0, 16'h0);
    chk("t5_rst_spawn", 32'(sp), 0);
    chk("t5_rst_wrap",  32'(wr), 0);
    rst = 1'b0;
    cyc(1, 4'b0001, 0, 0, 2'd0, 16'h0);
    chk("t5_restart_spawn", 32'({sp[2][0], sp[1][0], sp[0][0]}), 32'h7);

    // Partial enable: lanes 1 and 3 frozen, then everything runs and the model checks continuity.
    for (int k = 0; k < 5; k++) begin
      cyc(1, 4'b0101, 0, 0, 2'd0, 16'h0);
      chk($sformatf("t6_off_k%0d", k), 32'({sp[2][3], sp[2][1], sp[0][3], sp[0][1]}), 0);
    end
    for (int k = 0; k < 20; k++) cyc(1, 4'b1111, k[0], 0, 2'd0, 16'h0);

    cyc(0, 4'b0000, 0, 0, 2'd0, 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
